// File: rtl/z80_bus_bridge.sv
// -----------------------------------------------------------------------------
// z80_bus_bridge
//
// Purpose:
//   Turns the Z80 pin-level strobe bus (as produced by the TV80 wrapper) into a
//   single outstanding req/ack transaction toward the memory/IO fabric. The CPU
//   is stretched with wait_n until the fabric acknowledges or an optional
//   watchdog forces completion. Interrupt-acknowledge cycles never reach the
//   fabric; they are answered locally with a fixed vector.
//
// Parameters:
//   INT_VEC  - byte returned on cpu_di during interrupt acknowledge
//   TIMEOUT  - BUSY cycles before forced completion (0 = wait forever)
//   TO_DATA  - read data returned on a forced completion
//
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   mreq_n, iorq_n, rd_n, wr_n,
//   m1_n, rfsh_n, A, cpu_dout          - CPU-side strobes, address, write data
//   cpu_di, wait_n                     - data and wait back to the CPU
//   bus_req, bus_io, bus_we, bus_m1,
//   bus_addr, bus_wdata                - fabric request (level, held until ack)
//   bus_ack, bus_rdata                 - fabric completion pulse and read data
//   bus_timeout                        - one-cycle pulse on forced completion
// -----------------------------------------------------------------------------
module z80_bus_bridge #(
   parameter logic [7:0]  INT_VEC = 8'hFF,
   parameter int unsigned TIMEOUT = 64,
   parameter logic [7:0]  TO_DATA = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic        rfsh_n,
   input  logic [15:0] A,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_di,
   output logic        wait_n,
   output logic        bus_req,
   output logic        bus_io,
   output logic        bus_we,
   output logic        bus_m1,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata,
   output logic        bus_timeout
);

   // Counter just wide enough to reach TIMEOUT-1; one bit minimum so the
   // declaration stays legal when the watchdog is small or disabled.
   localparam int unsigned    CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam bit             TO_EN    = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Strobe decode
   // ---------------------------------------------------------------------------
   logic w_mem_rd;
   logic w_mem_wr;
   logic w_io_rd;
   logic w_io_wr;
   logic w_acc;
   logic w_inta;
   logic w_start;
   logic w_rfsh_unused;

   assign w_mem_rd = ~mreq_n & ~rd_n;
   assign w_mem_wr = ~mreq_n & ~wr_n;
   // IO terms exclude M1 so interrupt acknowledge (iorq_n with m1_n low) is
   // never mistaken for a port access.
   assign w_io_rd  = ~iorq_n &  m1_n & ~rd_n;
   assign w_io_wr  = ~iorq_n &  m1_n & ~wr_n;
   assign w_acc    = w_mem_rd | w_mem_wr | w_io_rd | w_io_wr;
   assign w_inta   = ~m1_n & ~iorq_n;

   // Refresh drives mreq_n low with rd_n/wr_n high, so it already matches no
   // access term; the pin itself carries no extra information here.
   assign w_rfsh_unused = rfsh_n;

   // ---------------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------------
   state_t           r_state;
   logic             r_acc_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_req;
   logic             r_bus_io;
   logic             r_bus_we;
   logic             r_bus_m1;
   logic [15:0]      r_bus_addr;
   logic [7:0]       r_bus_wdata;
   logic [7:0]       r_cpu_di;
   logic             r_bus_timeout;

   // A transaction only starts on a fresh rising edge of acc, and only from
   // IDLE; a strobe held low across DONE or across reset never re-triggers.
   assign w_start = (r_state == ST_IDLE) & w_acc & ~r_acc_d;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge value of every other register.
      if (reset) begin
         r_state       <= ST_IDLE;
         r_acc_d       <= 1'b1;        // treat strobes as already active
         r_cnt         <= '0;
         r_bus_req     <= 1'b0;
         r_bus_io      <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_m1      <= 1'b0;
         r_bus_addr    <= '0;
         r_bus_wdata   <= '0;
         r_cpu_di      <= 8'hFF;
         r_bus_timeout <= 1'b0;
      end else begin
         r_acc_d       <= w_acc;
         r_bus_timeout <= 1'b0;        // pulse by default

         unique case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_bus_addr  <= A;
                  r_bus_we    <= w_mem_wr | w_io_wr;
                  r_bus_io    <= ~iorq_n;
                  r_bus_m1    <= ~m1_n;
                  // acc rises on wr_n for writes, one T-state after mreq_n,
                  // so cpu_dout is already valid when it is captured here.
                  r_bus_wdata <= cpu_dout;
                  r_bus_req   <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= ST_BUSY;
               end
            end

            ST_BUSY: begin
               if (bus_ack) begin
                  // Ack has priority over a coincident watchdog expiry.
                  if (!r_bus_we) begin
                     r_cpu_di <= bus_rdata;
                  end
                  r_bus_req <= 1'b0;
                  r_state   <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (TO_EN && (r_cnt == CNT_LAST)) begin
                     if (!r_bus_we) begin
                        r_cpu_di <= TO_DATA;
                     end
                     r_bus_timeout <= 1'b1;
                     r_bus_req     <= 1'b0;
                     r_state       <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               // Hold cpu_di until the CPU drops its strobes. If they rise
               // again immediately, r_acc_d has seen the gap and IDLE starts
               // the next transaction on the following cycle.
               if (!w_acc) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus_req     = r_bus_req;
   assign bus_io      = r_bus_io;
   assign bus_we      = r_bus_we;
   assign bus_m1      = r_bus_m1;
   assign bus_addr    = r_bus_addr;
   assign bus_wdata   = r_bus_wdata;
   assign bus_timeout = r_bus_timeout;

   // The interrupt vector is muxed in combinationally so it is on the bus in
   // the same cycle the CPU raises the acknowledge.
   assign cpu_di = w_inta ? INT_VEC : r_cpu_di;

   // wait_n is combinational so the CPU sees it low in the very cycle the
   // strobe appears and its T2 sample cannot slip past. It is forced high
   // while reset is held, even if the registered state is still BUSY.
   assign wait_n = ~(~reset & w_acc &
                     (((r_state == ST_IDLE) & ~r_acc_d) | (r_state == ST_BUSY)));

endmodule

// File: tb/tb_z80_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_z80_bus_bridge
//
// Drives Z80 strobe sequences into z80_bus_bridge (TIMEOUT = 4 so the watchdog
// is reachable in a few cycles) and plays the fabric side by hand. Every issued
// request is matched against a queue of expected transactions filled when the
// stimulus is driven; each scenario task checks wait_n, cpu_di and the pulses.
// -----------------------------------------------------------------------------
module tb_z80_bus_bridge;

   localparam int unsigned TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
   logic [15:0] A;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_di;
   logic        wait_n;
   logic        bus_req, bus_io, bus_we, bus_m1;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_ack;
   logic [7:0]  bus_rdata;
   logic        bus_timeout;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic        io;
      logic        m1;
      logic [7:0]  wdata;
   } txn_t;

   txn_t exp_q[$];
   txn_t mon_exp;
   txn_t mon_got;
   logic prev_req = 1'b0;

   z80_bus_bridge #(
      .INT_VEC (8'hFF),
      .TIMEOUT (TB_TIMEOUT),
      .TO_DATA (8'hFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mreq_n      (mreq_n),
      .iorq_n      (iorq_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .m1_n        (m1_n),
      .rfsh_n      (rfsh_n),
      .A           (A),
      .cpu_dout    (cpu_dout),
      .cpu_di      (cpu_di),
      .wait_n      (wait_n),
      .bus_req     (bus_req),
      .bus_io      (bus_io),
      .bus_we      (bus_we),
      .bus_m1      (bus_m1),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata),
      .bus_timeout (bus_timeout)
   );

   always #5 clk = ~clk;

   // Scoreboard: every rising edge of bus_req must match the oldest expected
   // transaction; a request with nothing queued is a spurious transaction.
   always @(negedge clk) begin
      if (bus_req && !prev_req) begin
         mon_got = '{addr: bus_addr, we: bus_we, io: bus_io, m1: bus_m1, wdata: bus_wdata};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected_req: got request addr=%h we=%b, want no request",
                     bus_addr, bus_we);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_bad++;
               $display("FAIL sb_txn: got addr=%h we=%b io=%b m1=%b wd=%h, want addr=%h we=%b io=%b m1=%b wd=%h",
                        mon_got.addr, mon_got.we, mon_got.io, mon_got.m1, mon_got.wdata,
                        mon_exp.addr, mon_exp.we, mon_exp.io, mon_exp.m1, mon_exp.wdata);
            end
         end
      end
      prev_req = bus_req;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (no checking)
   // ---------------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic pins(input logic mreq, input logic iorq, input logic rd,
                       input logic wr, input logic m1, input logic rfsh);
      mreq_n = mreq;
      iorq_n = iorq;
      rd_n   = rd;
      wr_n   = wr;
      m1_n   = m1;
      rfsh_n = rfsh;
   endtask

   task automatic pins_idle();
      pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset     = 1'b1;
      pins_idle();
      A         = 16'h0000;
      cpu_dout  = 8'h00;
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
      cyc(3);
      smp();
      n_cmp++;
      if ({bus_req, bus_we, bus_io, bus_m1, bus_timeout} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got req/we/io/m1/to=%b, want 00000",
                  {bus_req, bus_we, bus_io, bus_m1, bus_timeout});
      end
      n_cmp++;
      if ({bus_addr, bus_wdata} !== 24'h0) begin
         n_bad++;
         $display("FAIL reset_fields: got addr=%h wdata=%h, want 0000/00", bus_addr, bus_wdata);
      end
      n_cmp++;
      if (cpu_di !== 8'hFF || wait_n !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_cpu: got cpu_di=%h wait_n=%b, want FF/1", cpu_di, wait_n);
      end
      cyc(1);
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_mem_read();
      int req_cyc = 0;
      int wait_lo = 0;
      int extra   = 0;
      cyc(1);
      cpu_dout = 8'h00;
      A        = 16'h0123;
      pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back('{addr: 16'h0123, we: 1'b0, io: 1'b0, m1: 1'b0, wdata: 8'h00});
      smp();
      if (!wait_n) wait_lo++;
      n_cmp++;
      if (bus_req !== 1'b0) begin
         n_bad++;
         $display("FAIL mrd_req_same_cycle: got bus_req=%b, want 0", bus_req);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         bus_ack   = (i == 2);
         bus_rdata = 8'h3E;
         smp();
         if (bus_req) req_cyc++;
         if (!wait_n) wait_lo++;
      end
      bus_ack = 1'b0;
      n_cmp++;
      if (req_cyc !== 3) begin
         n_bad++;
         $display("FAIL mrd_req_cycles: got %0d, want 3", req_cyc);
      end
      n_cmp++;
      if (wait_lo !== 4) begin
         n_bad++;
         $display("FAIL mrd_wait_cycles: got %0d, want 4", wait_lo);
      end
      n_cmp++;
      if (cpu_di !== 8'h3E || bus_we !== 1'b0 || bus_io !== 1'b0) begin
         n_bad++;
         $display("FAIL mrd_result: got cpu_di=%h we=%b io=%b, want 3E/0/0", cpu_di, bus_we, bus_io);
      end
      // Strobes stay low: the bridge must sit in DONE without re-requesting.
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         smp();
         if (bus_req || !wait_n) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_bad++;
         $display("FAIL mrd_hold_no_rereq: got %0d bad cycles, want 0", extra);
      end
      cyc(1);
      pins_idle();
   endtask

   task automatic test_mem_write();
      cyc(1);
      A        = 16'h4000;
      cpu_dout = 8'hA5;
      pins(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);   // mreq_n first, wr_n still high
      smp();
      n_cmp++;
      if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
         n_bad++;
         $display("FAIL mwr_mreq_only: got req=%b wait_n=%b, want 0/1", bus_req, wait_n);
      end
      cyc(1);
      wr_n = 1'b0;
      exp_q.push_back('{addr: 16'h4000, we: 1'b1, io: 1'b0, m1: 1'b0, wdata: 8'hA5});
      smp();
      n_cmp++;
      if (wait_n !== 1'b0) begin
         n_bad++;
         $display("FAIL mwr_wait_on_wr: got wait_n=%b, want 0", wait_n);
      end
      cyc(1);
      bus_ack   = 1'b1;
      bus_rdata = 8'h77;                           // must not reach cpu_di
      smp();
      n_cmp++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wdata !== 8'hA5 || bus_addr !== 16'h4000) begin
         n_bad++;
         $display("FAIL mwr_fields: got req=%b we=%b wd=%h addr=%h, want 1/1/A5/4000",
                  bus_req, bus_we, bus_wdata, bus_addr);
      end
      cyc(1);
      bus_ack = 1'b0;
      smp();
      n_cmp++;
      if (cpu_di !== 8'h3E || wait_n !== 1'b1 || bus_req !== 1'b0) begin
         n_bad++;
         $display("FAIL mwr_done: got cpu_di=%h wait_n=%b req=%b, want 3E/1/0", cpu_di, wait_n, bus_req);
      end
      cyc(1);
      pins_idle();
   endtask

   task automatic test_io_read();
      cyc(1);
      A        = 16'hFEFE;
      cpu_dout = 8'h00;
      pins(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back('{addr: 16'hFEFE, we: 1'b0, io: 1'b1, m1: 1'b0, wdata: 8'h00});
      cyc(1);
      bus_ack   = 1'b1;
      bus_rdata = 8'h1F;
      smp();
      n_cmp++;
      if (bus_req !== 1'b1 || bus_io !== 1'b1) begin
         n_bad++;
         $display("FAIL iord_req: got req=%b io=%b, want 1/1", bus_req, bus_io);
      end
      cyc(1);
      bus_ack = 1'b0;
      smp();
      n_cmp++;
      if (cpu_di !== 8'h1F || wait_n !== 1'b1) begin
         n_bad++;
         $display("FAIL iord_data: got cpu_di=%h wait_n=%b, want 1F/1", cpu_di, wait_n);
      end
      cyc(1);
      pins_idle();
   endtask

   task automatic test_inta();
      int bad = 0;
      cyc(1);
      pins(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      smp();
      n_cmp++;
      if (cpu_di !== 8'hFF) begin
         n_bad++;
         $display("FAIL inta_vector: got cpu_di=%h, want FF", cpu_di);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         smp();
         if (bus_req || !wait_n) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL inta_no_bus: got %0d cycles with req or wait, want 0", bad);
      end
      cyc(1);
      pins_idle();
      smp();
      n_cmp++;
      if (cpu_di !== 8'h1F) begin
         n_bad++;
         $display("FAIL inta_restore: got cpu_di=%h, want 1F", cpu_di);
      end
   endtask

   task automatic test_refresh();
      int bad = 0;
      cyc(1);
      A = 16'h0055;
      pins(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         smp();
         if (bus_req || !wait_n) bad++;
         cyc(1);
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL refresh_ignored: got %0d cycles with req or wait, want 0", bad);
      end
      pins_idle();
   endtask

   task automatic test_opcode_fetch();
      cyc(1);
      A = 16'h0038;
      pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      exp_q.push_back('{addr: 16'h0038, we: 1'b0, io: 1'b0, m1: 1'b1, wdata: 8'h00});
      cyc(1);
      bus_ack   = 1'b1;
      bus_rdata = 8'hC9;
      smp();
      n_cmp++;
      if (bus_m1 !== 1'b1 || bus_req !== 1'b1) begin
         n_bad++;
         $display("FAIL m1_flag: got m1=%b req=%b, want 1/1", bus_m1, bus_req);
      end
      cyc(1);
      bus_ack = 1'b0;
      smp();
      n_cmp++;
      if (cpu_di !== 8'hC9) begin
         n_bad++;
         $display("FAIL m1_data: got cpu_di=%h, want C9", cpu_di);
      end
      cyc(1);
      pins_idle();
   endtask

   // ack_at: BUSY cycle index (0-based) carrying bus_ack, or -1 for none.
   task automatic run_watchdog(input int ack_at, input logic [7:0] rdata,
                               output int req_cyc, output int to_cyc, output int to_at,
                               output int wait_lo, output logic [7:0] di_end,
                               output logic wn_end);
      req_cyc = 0;
      to_cyc  = 0;
      to_at   = -1;
      wait_lo = 0;
      cyc(1);
      A = 16'h1234;
      pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back('{addr: 16'h1234, we: 1'b0, io: 1'b0, m1: 1'b0, wdata: 8'h00});
      for (int i = 0; i < 7; i++) begin
         cyc(1);
         bus_ack   = (i == ack_at);
         bus_rdata = rdata;
         smp();
         if (bus_req) req_cyc++;
         if (bus_timeout) begin
            to_cyc++;
            to_at = i;
         end
         if (!wait_n && i < 4) wait_lo++;
         if (i == 4) begin
            di_end = cpu_di;
            wn_end = wait_n;
         end
      end
      bus_ack = 1'b0;
      pins_idle();
   endtask

   task automatic test_timeout();
      int req_cyc, to_cyc, to_at, wait_lo;
      logic [7:0] di_end;
      logic wn_end;
      run_watchdog(-1, 8'h00, req_cyc, to_cyc, to_at, wait_lo, di_end, wn_end);
      n_cmp++;
      if (req_cyc !== 4 || wait_lo !== 4) begin
         n_bad++;
         $display("FAIL to_busy_len: got req=%0d wait_lo=%0d, want 4/4", req_cyc, wait_lo);
      end
      n_cmp++;
      if (to_cyc !== 1 || to_at !== 4) begin
         n_bad++;
         $display("FAIL to_pulse: got %0d pulses at %0d, want 1 at 4", to_cyc, to_at);
      end
      n_cmp++;
      if (di_end !== 8'hFF || wn_end !== 1'b1) begin
         n_bad++;
         $display("FAIL to_result: got cpu_di=%h wait_n=%b, want FF/1", di_end, wn_end);
      end
   endtask

   task automatic test_ack_at_limit();
      int req_cyc, to_cyc, to_at, wait_lo;
      logic [7:0] di_end;
      logic wn_end;
      run_watchdog(3, 8'h5A, req_cyc, to_cyc, to_at, wait_lo, di_end, wn_end);
      n_cmp++;
      if (to_cyc !== 0) begin
         n_bad++;
         $display("FAIL ack_limit_no_to: got %0d timeout pulses, want 0", to_cyc);
      end
      n_cmp++;
      if (req_cyc !== 4 || di_end !== 8'h5A || wn_end !== 1'b1) begin
         n_bad++;
         $display("FAIL ack_limit_data: got req=%0d cpu_di=%h wait_n=%b, want 4/5A/1",
                  req_cyc, di_end, wn_end);
      end
   endtask

   task automatic test_reset_mid_busy();
      int bad = 0;
      cyc(1);
      A = 16'h8000;
      pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back('{addr: 16'h8000, we: 1'b0, io: 1'b0, m1: 1'b0, wdata: 8'h00});
      cyc(2);                                      // now in second BUSY cycle
      reset = 1'b1;
      smp();
      n_cmp++;
      if (wait_n !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_busy_wait: got wait_n=%b, want 1", wait_n);
      end
      cyc(1);
      smp();
      n_cmp++;
      if (bus_req !== 1'b0 || wait_n !== 1'b1 || cpu_di !== 8'hFF) begin
         n_bad++;
         $display("FAIL rst_busy_clear: got req=%b wait_n=%b cpu_di=%h, want 0/1/FF",
                  bus_req, wait_n, cpu_di);
      end
      cyc(1);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         smp();
         if (bus_req || !wait_n) bad++;
         cyc(1);
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL rst_held_strobe: got %0d cycles with req or wait, want 0", bad);
      end
      pins_idle();
      cyc(1);
      A = 16'h8001;
      pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back('{addr: 16'h8001, we: 1'b0, io: 1'b0, m1: 1'b0, wdata: 8'h00});
      cyc(1);
      bus_ack   = 1'b1;
      bus_rdata = 8'h66;
      smp();
      n_cmp++;
      if (bus_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_fresh_edge: got bus_req=%b, want 1", bus_req);
      end
      cyc(1);
      bus_ack = 1'b0;
      smp();
      n_cmp++;
      if (cpu_di !== 8'h66) begin
         n_bad++;
         $display("FAIL rst_fresh_data: got cpu_di=%h, want 66", cpu_di);
      end
      cyc(1);
      pins_idle();
   endtask

   task automatic test_back_to_back();
      cyc(1);
      A = 16'h2000;
      pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back('{addr: 16'h2000, we: 1'b0, io: 1'b0, m1: 1'b0, wdata: 8'h00});
      cyc(1);
      bus_ack   = 1'b1;
      bus_rdata = 8'h11;
      cyc(1);                                      // DONE; strobes drop for one cycle
      bus_ack = 1'b0;
      pins_idle();
      cyc(1);                                      // IDLE; strobes fall again at once
      A = 16'h2001;
      pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back('{addr: 16'h2001, we: 1'b0, io: 1'b0, m1: 1'b0, wdata: 8'h00});
      smp();
      n_cmp++;
      if (wait_n !== 1'b0 || cpu_di !== 8'h11) begin
         n_bad++;
         $display("FAIL b2b_restart: got wait_n=%b cpu_di=%h, want 0/11", wait_n, cpu_di);
      end
      cyc(1);
      bus_ack   = 1'b1;
      bus_rdata = 8'h22;
      smp();
      n_cmp++;
      if (bus_req !== 1'b1 || bus_addr !== 16'h2001) begin
         n_bad++;
         $display("FAIL b2b_req: got req=%b addr=%h, want 1/2001", bus_req, bus_addr);
      end
      cyc(1);
      bus_ack = 1'b0;
      smp();
      n_cmp++;
      if (cpu_di !== 8'h22 || wait_n !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_data: got cpu_di=%h wait_n=%b, want 22/1", cpu_di, wait_n);
      end
      cyc(1);
      pins_idle();
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_mem_write();
      test_io_read();
      test_inta();
      test_refresh();
      test_opcode_fetch();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid_busy();
      test_back_to_back();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d expected requests never issued, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/z80_bus_bridge.md
Name: z80_bus_bridge

Overview:
- Sits directly downstream of the TV80 pin-level CPU wrapper.
- Converts the Z80 strobe bus (mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n, A, dout) into a single-transaction req/ack handshake toward the memory/IO fabric.
- Stretches the CPU with wait_n until the fabric acknowledges. Returns read data on cpu_di and answers interrupt-acknowledge cycles with a fixed vector.

Parameters:
- INT_VEC, 8'hFF, data returned to the CPU during an interrupt-acknowledge cycle (RST 38h on the ZX81).
- TIMEOUT, 64, maximum clk cycles in BUSY before forced completion; 0 disables the timeout.
- TO_DATA, 8'hFF, read data returned on a forced completion.

Ports:
- clk, input, 1, system clock; the same clock that drives the CPU wrapper.
- reset, input, 1, synchronous active-high reset.
- mreq_n, input, 1, CPU memory request.
- iorq_n, input, 1, CPU IO request.
- rd_n, input, 1, CPU read strobe.
- wr_n, input, 1, CPU write strobe.
- m1_n, input, 1, CPU opcode-fetch / interrupt-ack marker.
- rfsh_n, input, 1, CPU refresh marker.
- A, input, 16, CPU address.
- cpu_dout, input, 8, CPU write data.
- cpu_di, output, 8, data to CPU di.
- wait_n, output, 1, to CPU wait_n.
- bus_req, output, 1, transaction request, level, held until ack.
- bus_io, output, 1, 1 = IO space, 0 = memory.
- bus_we, output, 1, 1 = write.
- bus_m1, output, 1, the transaction is an opcode fetch.
- bus_addr, output, 16, latched address.
- bus_wdata, output, 8, latched write data.
- bus_ack, input, 1, single-cycle completion pulse.
- bus_rdata, input, 8, read data, valid with bus_ack.
- bus_timeout, output, 1, single-cycle pulse on forced completion.

Behaviour:
- Decode, combinational from the CPU pins:
  - mem_rd = ~mreq_n & ~rd_n
  - mem_wr = ~mreq_n & ~wr_n
  - io_rd = ~iorq_n & m1_n & ~rd_n
  - io_wr = ~iorq_n & m1_n & ~wr_n
  - acc = OR of these four
  - inta = ~m1_n & ~iorq_n
- Refresh (mreq_n low, rfsh_n low, rd_n/wr_n high) matches no term and is ignored.
- acc_d is a register of acc and resets to 1, so a strobe already low at reset release never starts a transaction. A transaction starts only on acc rising (acc & ~acc_d).
- States: IDLE, BUSY, DONE.
- IDLE:
  - On start, latch bus_addr=A, bus_we=(mem_wr|io_wr), bus_io=~iorq_n, bus_m1=~m1_n, bus_wdata=cpu_dout.
  - Set bus_req=1, clear the timeout counter, go to BUSY.
- BUSY:
  - bus_req stays 1 with all latched fields stable.
  - On bus_ack: cpu_di<=bus_rdata (reads only; writes leave cpu_di unchanged), bus_req<=0, go to DONE.
  - Else the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1: cpu_di<=TO_DATA (reads only), bus_timeout pulses 1 cycle, bus_req<=0, go to DONE.
  - bus_ack and the timeout in the same cycle: ack wins and there is no timeout pulse.
- DONE: hold cpu_di. When acc==0 return to IDLE. A new acc rising edge in that same cycle is honoured on the next IDLE cycle, because acc_d captures it.
- bus_ack outside BUSY is ignored.
- wait_n (combinational) = ~(acc & ((state==IDLE & ~acc_d) | state==BUSY)).
  - This pulls wait low in the very cycle the strobe appears, so the CPU T2 sample never misses it.
  - wait_n releases in the cycle after ack (state==DONE).
- inta:
  - cpu_di = INT_VEC combinationally while inta is 1; this overrides the registered value.
  - No bus transaction is issued and wait_n stays 1.
- Write cycles: wr_n falls one CPU T-state after mreq_n. acc rises on wr_n, so bus_wdata is captured once the CPU drives valid dout.
- Reset (any state, including mid-BUSY):
  - Outputs: bus_req=0, bus_we=0, bus_io=0, bus_m1=0, bus_addr=0, bus_wdata=0, cpu_di=8'hFF, bus_timeout=0.
  - Internal: state=IDLE, acc_d=1, counter=0.
  - wait_n=1 during reset and until a fresh edge.
- Latency: minimum stretch is 1 clk between start and ack when ack arrives the cycle after bus_req rises. cpu_di is valid the cycle wait_n returns high.

Test Plan:
- Memory read: mreq_n/rd_n fall with A=16'h0123, ack after 3 cycles with rdata=8'h3E -> bus_req high 3 cycles, bus_we=0, bus_io=0; wait_n low until ack+1; cpu_di=8'h3E; no second request while the strobes stay low.
- Memory write: mreq_n low, then wr_n low with cpu_dout=8'hA5, A=16'h4000 -> bus_we=1, bus_wdata=8'hA5, bus_addr=16'h4000; cpu_di unchanged.
- IO read from port 16'hFEFE with rdata=8'h1F -> bus_io=1; cpu_di=8'h1F. inta (m1_n=0, iorq_n=0) -> cpu_di=8'hFF, bus_req stays 0, wait_n stays 1.
- Refresh (mreq_n=0, rfsh_n=0, rd_n=wr_n=1) -> no bus_req, wait_n=1. Opcode fetch (m1_n=0) -> bus_m1=1.
- TIMEOUT=4, no ack on a read -> bus_timeout pulse on the 4th BUSY cycle, cpu_di=8'hFF, wait_n released. Ack coincident with the last count -> rdata used, no timeout pulse.
- Reset asserted mid-BUSY with the strobes held low -> bus_req=0, wait_n=1. After release, no new request until the strobes go high and fall again.
